// File: rtl/uart_io_arbiter.sv
// IO-bus front end for rs232_uart: port decode, one-entry TX pend register, round-robin TX sharing with a button echo path; UART_IO_TXCOUNT_EN adds a TX byte counter on ports 05/06.
// Latency: IO_read_data registered on the strobe edge; a TX grant drives uart_write_tx the following cycle.
// Backpressure: uart_tx_full stalls both sources, one cooldown cycle after every TX write, a proc write while pending is dropped (ovf).
module uart_io_arbiter #(
    parameter logic [7:0] UART_PORT = 8'h01,
    parameter logic [7:0] RXP_PORT  = 8'h02,
    parameter logic [7:0] TXB_PORT  = 8'h03,
    parameter logic [7:0] STAT_PORT = 8'h04
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    input  logic       dbg_echo,
    output logic [7:0] uart_tx_data,
    output logic       uart_write_tx,
    input  logic       uart_tx_full,
    input  logic [7:0] uart_rx_data,
    output logic       uart_read_ack,
    input  logic       uart_rx_present
);

    localparam logic [7:0] TXC_LO_PORT = 8'h05;
    localparam logic [7:0] TXC_HI_PORT = 8'h06;

    typedef enum logic [1:0] {E_IDLE, E_READ, E_HOLD} echo_state_t;

    echo_state_t state;
    logic [7:0]  pend_data;
    logic        pend_valid;
    logic [7:0]  echo_buf;
    logic        echo_valid;
    logic        ovf;
    logic        echo_drop;
    logic        rr_last;
    logic        cooldown;
    logic        dbg_sync1, dbg_sync2, dbg_prev;

    logic        rd_uart, wr_en, wr_uart, wr_stat;
    logic        echo_req, echo_busy, echo_take, drop_set;
    logic        tx_ok, grant_echo, grant_proc;
    logic [7:0]  rd_mux;

`ifdef UART_IO_TXCOUNT_EN
    logic [15:0] tx_count;
    logic [7:0]  tx_count_shadow;
`endif

    // A simultaneous read strobe wins; the write is discarded.
    assign rd_uart   = IO_read_strobe && (IO_port_ID == UART_PORT);
    assign wr_en     = IO_write_strobe && !IO_read_strobe;
    assign wr_uart   = wr_en && (IO_port_ID == UART_PORT);
    assign wr_stat   = wr_en && (IO_port_ID == STAT_PORT);

    assign echo_req  = dbg_sync2 && !dbg_prev;
    assign echo_busy = (state != E_IDLE);
    assign echo_take = (state == E_READ) && !rd_uart && uart_rx_present;
    assign drop_set  = (echo_req && (echo_busy || !uart_rx_present)) ||
                       ((state == E_READ) && !rd_uart && !uart_rx_present);

    // Both valid: serve the source that did not go last (rr_last 0 = proc).
    assign tx_ok      = !uart_tx_full && !cooldown;
    assign grant_echo = tx_ok && echo_valid && (!pend_valid || !rr_last);
    assign grant_proc = tx_ok && pend_valid && !grant_echo;

    // The pop must land on the same edge that captures the RX head.
    assign uart_read_ack = !reset && (rd_uart || echo_take);

    always_comb begin
        rd_mux = 8'h00;
        case (IO_port_ID)
            UART_PORT:   rd_mux = uart_rx_data;
            RXP_PORT:    rd_mux = {7'b0, uart_rx_present};
            TXB_PORT:    rd_mux = {7'b0, uart_tx_full | pend_valid};
            STAT_PORT:   rd_mux = {5'b0, echo_busy, echo_drop, ovf};
`ifdef UART_IO_TXCOUNT_EN
            TXC_LO_PORT: rd_mux = tx_count[7:0];
            TXC_HI_PORT: rd_mux = tx_count_shadow;
`endif
            default:     rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            IO_read_data  <= 8'h00;
            uart_tx_data  <= 8'h00;
            uart_write_tx <= 1'b0;
            pend_data     <= 8'h00;
            pend_valid    <= 1'b0;
            echo_buf      <= 8'h00;
            echo_valid    <= 1'b0;
            ovf           <= 1'b0;
            echo_drop     <= 1'b0;
            rr_last       <= 1'b0;
            cooldown      <= 1'b0;
            dbg_sync1     <= 1'b0;
            dbg_sync2     <= 1'b0;
            dbg_prev      <= 1'b0;
            state         <= E_IDLE;
        end else begin
            if (IO_read_strobe)
                IO_read_data <= rd_mux;

            dbg_sync1 <= dbg_echo;
            dbg_sync2 <= dbg_sync1;
            dbg_prev  <= dbg_sync2;

            uart_write_tx <= grant_echo || grant_proc;
            cooldown      <= grant_echo || grant_proc;
            if (grant_echo) begin
                uart_tx_data <= echo_buf;
                rr_last      <= 1'b1;
            end else if (grant_proc) begin
                uart_tx_data <= pend_data;
                rr_last      <= 1'b0;
            end

            // A write landing on the grant cycle refills the slot being drained.
            if (wr_uart && (!pend_valid || grant_proc)) begin
                pend_data  <= IO_write_data;
                pend_valid <= 1'b1;
            end else if (grant_proc) begin
                pend_valid <= 1'b0;
            end

            if (wr_uart && pend_valid && !grant_proc)
                ovf <= 1'b1;
            else if (wr_stat && IO_write_data[0])
                ovf <= 1'b0;

            if (drop_set)
                echo_drop <= 1'b1;
            else if (wr_stat && IO_write_data[1])
                echo_drop <= 1'b0;

            if (grant_echo)
                echo_valid <= 1'b0;

            case (state)
                E_IDLE: begin
                    if (echo_req && uart_rx_present)
                        state <= E_READ;
                end
                E_READ: begin
                    if (!rd_uart) begin
                        if (uart_rx_present) begin
                            echo_buf   <= uart_rx_data;
                            echo_valid <= 1'b1;
                            state      <= E_HOLD;
                        end else begin
                            state <= E_IDLE;
                        end
                    end
                end
                E_HOLD: begin
                    if (!echo_valid)
                        state <= E_IDLE;
                end
                default: state <= E_IDLE;
            endcase
        end
    end

`ifdef UART_IO_TXCOUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_count        <= 16'h0000;
            tx_count_shadow <= 8'h00;
        end else begin
            if (wr_en && (IO_port_ID == TXC_LO_PORT))
                tx_count <= 16'h0000;
            else if (uart_write_tx)
                tx_count <= tx_count + 16'd1;
            // Reading the low byte freezes the high byte for a coherent 16-bit read.
            if (IO_read_strobe && (IO_port_ID == TXC_LO_PORT))
                tx_count_shadow <= tx_count[15:8];
        end
    end
`endif

endmodule

// File: tb/tb_uart_io_arbiter.sv
// Directed bench for uart_io_arbiter: read-decode vector table plus hand sequences for pend, overflow, echo, round-robin and reset.
module tb_uart_io_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IO_port_ID;
    logic [7:0] IO_write_data;
    logic       IO_write_strobe;
    logic       IO_read_strobe;
    logic [7:0] IO_read_data;
    logic       dbg_echo;
    logic [7:0] uart_tx_data;
    logic       uart_write_tx;
    logic       uart_tx_full;
    logic [7:0] uart_rx_data;
    logic       uart_read_ack;
    logic       uart_rx_present;

    always #5 clk = ~clk;

    uart_io_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data),
        .dbg_echo        (dbg_echo),
        .uart_tx_data    (uart_tx_data),
        .uart_write_tx   (uart_write_tx),
        .uart_tx_full    (uart_tx_full),
        .uart_rx_data    (uart_rx_data),
        .uart_read_ack   (uart_read_ack),
        .uart_rx_present (uart_rx_present)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse observer, sampled mid-cycle.
    logic [7:0] tx_q[$];
    int ack_cnt = 0;
    int cyc     = 0;
    int last_tx = -10;
    int gap_err = 0;

    always @(negedge clk) begin
        cyc++;
        if (uart_write_tx === 1'b1) begin
            if (cyc - last_tx < 2) gap_err++;
            last_tx = cyc;
            tx_q.push_back(uart_tx_data);
        end
        if (uart_read_ack === 1'b1) ack_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic io_read(input logic [7:0] port, output logic [7:0] data);
        IO_port_ID     = port;
        IO_read_strobe = 1'b1;
        tick();
        IO_read_strobe = 1'b0;
        data = IO_read_data;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        IO_port_ID      = port;
        IO_write_data   = data;
        IO_write_strobe = 1'b1;
        tick();
        IO_write_strobe = 1'b0;
    endtask

    task automatic pulse_echo();
        dbg_echo = 1'b1;
        wait_n(3);
        dbg_echo = 1'b0;
        wait_n(4);
    endtask

    typedef struct {
        logic       rxp;
        logic [7:0] rxd;
        logic       full;
        logic [7:0] port;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[12];

    initial begin
        logic [7:0] d;
        int a0;

        vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h01, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 8'h02, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h03, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h04, 8'h00};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h7F, 8'h00};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h05, 8'h00};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h06, 8'h00};
        vecs[7]  = '{1'b1, 8'hA5, 1'b1, 8'h01, 8'hA5};
        vecs[8]  = '{1'b1, 8'hA5, 1'b1, 8'h02, 8'h01};
        vecs[9]  = '{1'b1, 8'hA5, 1'b1, 8'h03, 8'h01};
        vecs[10] = '{1'b1, 8'hA5, 1'b0, 8'h03, 8'h00};
        vecs[11] = '{1'b1, 8'h3C, 1'b0, 8'h7F, 8'h00};

        reset           = 1'b1;
        IO_port_ID      = 8'h00;
        IO_write_data   = 8'h00;
        IO_write_strobe = 1'b0;
        IO_read_strobe  = 1'b0;
        dbg_echo        = 1'b0;
        uart_tx_full    = 1'b0;
        uart_rx_data    = 8'h00;
        uart_rx_present = 1'b0;
        wait_n(3);
        check8("rst_read_data", IO_read_data, 8'h00);
        check8("rst_write_tx", {7'b0, uart_write_tx}, 8'h00);
        check8("rst_tx_data", uart_tx_data, 8'h00);
        check8("rst_read_ack", {7'b0, uart_read_ack}, 8'h00);
        reset = 1'b0;
        tick();

        // Read decode table
        for (int i = 0; i < 12; i++) begin
            uart_rx_present = vecs[i].rxp;
            uart_rx_data    = vecs[i].rxd;
            uart_tx_full    = vecs[i].full;
            io_read(vecs[i].port, d);
            check8($sformatf("vec%0d_port%02h", i, vecs[i].port), d, vecs[i].exp);
        end
        checkn("vec_ack_count", ack_cnt, 2);
        checkn("vec_no_tx", tx_q.size(), 0);
        uart_rx_present = 1'b0;
        uart_rx_data    = 8'h00;
        uart_tx_full    = 1'b0;

        // Pend held while TX full, released later
        uart_tx_full = 1'b1;
        io_write(8'h01, 8'h41);
        wait_n(10);
        io_read(8'h03, d);
        check8("pend_busy", d, 8'h01);
        checkn("pend_no_tx_while_full", tx_q.size(), 0);
        uart_tx_full = 1'b0;
        wait_n(4);
        checkn("pend_tx_count", tx_q.size(), 1);
        check8("pend_tx_byte", tx_q[0], 8'h41);
        io_read(8'h03, d);
        check8("pend_idle", d, 8'h00);

        // Overflow while pending
        uart_tx_full = 1'b1;
        io_write(8'h01, 8'h41);
        io_write(8'h01, 8'h42);
        io_read(8'h04, d);
        check8("ovf_set", d, 8'h01);
        uart_tx_full = 1'b0;
        wait_n(4);
        checkn("ovf_tx_count", tx_q.size(), 2);
        check8("ovf_tx_byte", tx_q[1], 8'h41);
        io_write(8'h04, 8'h01);
        io_read(8'h04, d);
        check8("ovf_cleared", d, 8'h00);

        // Read and write strobes together: write discarded
        IO_port_ID      = 8'h01;
        IO_write_data   = 8'h77;
        IO_read_strobe  = 1'b1;
        IO_write_strobe = 1'b1;
        tick();
        IO_read_strobe  = 1'b0;
        IO_write_strobe = 1'b0;
        wait_n(4);
        checkn("rdwr_no_tx", tx_q.size(), 2);
        io_read(8'h03, d);
        check8("rdwr_no_pend", d, 8'h00);

        // Write on the grant cycle refills the slot without ovf
        io_write(8'h01, 8'h41);
        io_write(8'h01, 8'h42);
        wait_n(6);
        checkn("refill_tx_count", tx_q.size(), 4);
        check8("refill_first", tx_q[2], 8'h41);
        check8("refill_second", tx_q[3], 8'h42);
        io_read(8'h04, d);
        check8("refill_no_ovf", d, 8'h00);

        // Button echo loopback
        uart_rx_present = 1'b1;
        uart_rx_data    = 8'h5A;
        a0 = ack_cnt;
        dbg_echo = 1'b1;
        wait_n(3);
        io_read(8'h04, d);
        check8("echo_busy", d, 8'h04);
        dbg_echo = 1'b0;
        wait_n(6);
        checkn("echo_ack_once", ack_cnt - a0, 1);
        checkn("echo_tx_count", tx_q.size(), 5);
        check8("echo_tx_byte", tx_q[4], 8'h5A);
        io_read(8'h04, d);
        check8("echo_done", d, 8'h00);

        // Round-robin: echo went last, so proc first
        uart_tx_full = 1'b1;
        io_write(8'h01, 8'h41);
        pulse_echo();
        checkn("rr1_held", tx_q.size(), 5);
        io_read(8'h04, d);
        check8("rr1_hold_busy", d, 8'h04);
        uart_tx_full = 1'b0;
        wait_n(8);
        checkn("rr1_tx_count", tx_q.size(), 7);
        check8("rr1_first", tx_q[5], 8'h41);
        check8("rr1_second", tx_q[6], 8'h5A);

        // Proc goes last, so echo first
        io_write(8'h01, 8'h33);
        wait_n(4);
        checkn("rr2_solo_count", tx_q.size(), 8);
        check8("rr2_solo_byte", tx_q[7], 8'h33);
        uart_tx_full = 1'b1;
        io_write(8'h01, 8'h41);
        pulse_echo();
        uart_tx_full = 1'b0;
        wait_n(8);
        checkn("rr2_tx_count", tx_q.size(), 10);
        check8("rr2_first", tx_q[8], 8'h5A);
        check8("rr2_second", tx_q[9], 8'h41);

        // Echo with RX empty is dropped
        uart_rx_present = 1'b0;
        a0 = ack_cnt;
        pulse_echo();
        checkn("drop_empty_no_tx", tx_q.size(), 10);
        checkn("drop_empty_no_ack", ack_cnt - a0, 0);
        io_read(8'h04, d);
        check8("drop_empty_stat", d, 8'h02);
        io_write(8'h04, 8'h02);
        io_read(8'h04, d);
        check8("drop_cleared", d, 8'h00);

        // Echo request while busy is dropped
        uart_rx_present = 1'b1;
        uart_tx_full    = 1'b1;
        a0 = ack_cnt;
        pulse_echo();
        pulse_echo();
        io_read(8'h04, d);
        check8("drop_busy_stat", d, 8'h06);
        checkn("drop_busy_ack", ack_cnt - a0, 1);
        uart_tx_full = 1'b0;
        wait_n(4);
        checkn("drop_busy_tx_count", tx_q.size(), 11);
        check8("drop_busy_tx_byte", tx_q[10], 8'h5A);
        io_read(8'h04, d);
        check8("drop_busy_after", d, 8'h02);
        io_write(8'h04, 8'h03);

        // TX counter ports
`ifdef UART_IO_TXCOUNT_EN
        io_read(8'h05, d);
        check8("txc_low", d, 8'h0B);
        io_read(8'h06, d);
        check8("txc_high", d, 8'h00);
        io_write(8'h05, 8'h00);
        io_read(8'h05, d);
        check8("txc_cleared", d, 8'h00);
`else
        io_read(8'h05, d);
        check8("port05_unmapped", d, 8'h00);
        io_read(8'h06, d);
        check8("port06_unmapped", d, 8'h00);
`endif

        // Reset with pend and echo both held
        uart_tx_full = 1'b1;
        io_write(8'h01, 8'h41);
        pulse_echo();
        reset        = 1'b1;
        uart_tx_full = 1'b0;
        tick();
        check8("midrst_no_pulse", {7'b0, uart_write_tx}, 8'h00);
        check8("midrst_read_data", IO_read_data, 8'h00);
        reset = 1'b0;
        wait_n(6);
        checkn("midrst_discarded", tx_q.size(), 11);
        io_read(8'h03, d);
        check8("midrst_txb", d, 8'h00);
        io_read(8'h04, d);
        check8("midrst_stat", d, 8'h00);

        checkn("tx_spacing", gap_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
